avalon_timer_tick_master: RTL

- Avalon-MM initiator that drives the 16-bit-data, 3-bit-address interval-timer slave in the niosII system.
- On command it stops and configures the timer, then starts it in continuous mode with interrupt enabled.
- It services each timer irq by clearing status, reading back status and counting ticks, so periodic ticks are available without CPU involvement.
- It sits between fabric logic (start/stop, tick consumers) and the timer's s1 slave port.

---
 rtl/avalon_timer_tick_master.sv | 131 +++++++++++++
 1 files changed

// File: rtl/avalon_timer_tick_master.sv
// avalon_timer_tick_master: configures the interval timer and services its irq as periodic ticks
module avalon_timer_tick_master #(
  parameter logic [15:0] PERIOD_L   = 16'h0063,
  parameter logic [15:0] PERIOD_H   = 16'h0000,
  parameter int          TICK_LIMIT = 0,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             irq,
  output logic [2:0]       avm_address,
  output logic             avm_chipselect,
  output logic             avm_write_n,
  output logic [15:0]      avm_writedata,
  input  logic [15:0]      avm_readdata,
  output logic             tick_pulse,
  output logic [CNT_W-1:0] tick_count,
  output logic             busy,
  output logic             done,
  output logic             err
);
  typedef enum logic [3:0] {
    IDLE, WR_STOP, WR_PERL, WR_PERH, WR_CTRL, RUN, CLR_STAT, RD_STAT, RD_WAIT, WR_HALT
  } state_t;
  state_t state;
  logic stop_lat;
  logic stop_pend;
  logic limit_hit;
  logic unused_rd;
  assign stop_pend = stop_lat | stop;
  assign limit_hit = (TICK_LIMIT != 0) && (tick_count == CNT_W'(TICK_LIMIT));
  assign unused_rd = ^{avm_readdata[15:2], avm_readdata[0]};
  // The register for each state holds the transfer currently on the bus, so outputs load with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      stop_lat       <= 1'b0;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_address    <= '0;
      avm_writedata  <= '0;
      tick_pulse     <= 1'b0;
      tick_count     <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
    end else begin
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      tick_pulse     <= 1'b0;
      done           <= 1'b0;
      if (state != IDLE && state != WR_HALT && stop) stop_lat <= 1'b1;
      case (state)
        IDLE: if (start && !stop) begin
          state          <= WR_STOP;
          busy           <= 1'b1;
          tick_count     <= '0;
          err            <= 1'b0;
          stop_lat       <= 1'b0;
          avm_chipselect <= 1'b1;
          avm_write_n    <= 1'b0;
          avm_address    <= 3'd1;
          avm_writedata  <= 16'h0008;
        end
        WR_STOP: begin
          state          <= WR_PERL;
          avm_chipselect <= 1'b1;
          avm_write_n    <= 1'b0;
          avm_address    <= 3'd2;
          avm_writedata  <= PERIOD_L;
        end
        WR_PERL: begin
          state          <= WR_PERH;
          avm_chipselect <= 1'b1;
          avm_write_n    <= 1'b0;
          avm_address    <= 3'd3;
          avm_writedata  <= PERIOD_H;
        end
        WR_PERH: begin
          state          <= WR_CTRL;
          avm_chipselect <= 1'b1;
          avm_write_n    <= 1'b0;
          avm_address    <= 3'd1;
          avm_writedata  <= 16'h0007;
        end
        WR_CTRL: state <= RUN;
        RUN: if (stop_pend) begin
          state          <= WR_HALT;
          stop_lat       <= 1'b0;
          avm_chipselect <= 1'b1;
          avm_write_n    <= 1'b0;
          avm_address    <= 3'd1;
          avm_writedata  <= 16'h0008;
        end else if (irq) begin
          state          <= CLR_STAT;
          tick_count     <= tick_count + CNT_W'(1);
          tick_pulse     <= 1'b1;
          avm_chipselect <= 1'b1;
          avm_write_n    <= 1'b0;
          avm_address    <= 3'd0;
          avm_writedata  <= 16'h0000;
        end
        CLR_STAT: begin
          state          <= RD_STAT;
          avm_chipselect <= 1'b1;
          avm_address    <= 3'd0;
        end
        RD_STAT: state <= RD_WAIT;
        RD_WAIT: begin
          if (!avm_readdata[1]) err <= 1'b1;
          if (limit_hit) begin
            state          <= WR_HALT;
            stop_lat       <= 1'b0;
            avm_chipselect <= 1'b1;
            avm_write_n    <= 1'b0;
            avm_address    <= 3'd1;
            avm_writedata  <= 16'h0008;
          end else state <= RUN;
        end
        WR_HALT: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
